// File: rtl/ras_spec_ctrl.sv
// Speculative return-address stack with a committed shadow copy.
// A flush restores the speculative copy from the committed one in a single cycle.
module ras_spec_ctrl #(
  parameter int ADDR  = 32,
  parameter int DEPTH = 8,
  parameter int INCR  = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_call_,
  input  logic [ADDR-1:0] fetch_pc,
  input  logic            fetch_ret_,
  output logic            ret_v,
  output logic [ADDR-1:0] ret_addr,
  input  logic            commit_call_,
  input  logic [ADDR-1:0] commit_pc,
  input  logic            commit_ret_,
  input  logic            flush_,
  output logic [CW-1:0]   spec_cnt,
  output logic [CW-1:0]   commit_cnt
);

  logic [DEPTH-1:0][ADDR-1:0] spec, spec_next;
  logic [DEPTH-1:0][ADDR-1:0] cmt, cmt_next;
  logic [PW-1:0]              sp, sp_next, sp_top;
  logic [PW-1:0]              cp, cp_next, cp_top;
  logic [CW-1:0]              scnt, scnt_next;
  logic [CW-1:0]              ccnt, ccnt_next;

  logic            fetch_push, fetch_pop, commit_push, commit_pop, flush;
  logic [ADDR-1:0] fetch_val, commit_val;

  assign fetch_push  = ~fetch_call_;
  assign fetch_pop   = ~fetch_ret_;
  assign commit_push = ~commit_call_;
  assign commit_pop  = ~commit_ret_;
  assign flush       = ~flush_;

  assign fetch_val  = fetch_pc + ADDR'(INCR);
  assign commit_val = commit_pc + ADDR'(INCR);

  assign sp_top = sp - PW'(1);
  assign cp_top = cp - PW'(1);

  // Committed stack; a push on a full stack overwrites the oldest slot.
  always_comb begin
    cmt_next  = cmt;
    cp_next   = cp;
    ccnt_next = ccnt;
    if (commit_push && commit_pop && ccnt != '0) begin
      cmt_next[cp_top] = commit_val;
    end else if (commit_push) begin
      cmt_next[cp] = commit_val;
      cp_next      = cp + PW'(1);
      if (ccnt != CW'(DEPTH)) ccnt_next = ccnt + CW'(1);
    end else if (commit_pop && ccnt != '0) begin
      cp_next   = cp_top;
      ccnt_next = ccnt - CW'(1);
    end
  end

  // Speculative stack; flush copies the post-update committed state and drops fetch strobes.
  always_comb begin
    spec_next = spec;
    sp_next   = sp;
    scnt_next = scnt;
    if (flush) begin
      spec_next = cmt_next;
      sp_next   = cp_next;
      scnt_next = ccnt_next;
    end else if (fetch_push && fetch_pop && scnt != '0) begin
      spec_next[sp_top] = fetch_val;
    end else if (fetch_push) begin
      spec_next[sp] = fetch_val;
      sp_next       = sp + PW'(1);
      if (scnt != CW'(DEPTH)) scnt_next = scnt + CW'(1);
    end else if (fetch_pop && scnt != '0) begin
      sp_next   = sp_top;
      scnt_next = scnt - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spec <= '0;
      sp   <= '0;
      scnt <= '0;
      cmt  <= '0;
      cp   <= '0;
      ccnt <= '0;
    end else begin
      spec <= spec_next;
      sp   <= sp_next;
      scnt <= scnt_next;
      cmt  <= cmt_next;
      cp   <= cp_next;
      ccnt <= ccnt_next;
    end
  end

  assign ret_v      = (scnt != '0);
  assign ret_addr   = ret_v ? spec[sp_top] : '0;
  assign spec_cnt   = scnt;
  assign commit_cnt = ccnt;

endmodule

// File: tb/tb_ras_spec_ctrl.sv
// Directed plus randomized bench for ras_spec_ctrl (DEPTH=4, INCR=4).
// Both stacks are modelled as bounded queues; overflow drops the front element.
module tb_ras_spec_ctrl;

  localparam int ADDR  = 32;
  localparam int DEPTH = 4;
  localparam int INCR  = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef logic [ADDR-1:0] addr_q_t[$];

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            fetch_call_ = 1'b1;
  logic [ADDR-1:0] fetch_pc = '0;
  logic            fetch_ret_ = 1'b1;
  logic            ret_v;
  logic [ADDR-1:0] ret_addr;
  logic            commit_call_ = 1'b1;
  logic [ADDR-1:0] commit_pc = '0;
  logic            commit_ret_ = 1'b1;
  logic            flush_ = 1'b1;
  logic [CW-1:0]   spec_cnt;
  logic [CW-1:0]   commit_cnt;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  addr_q_t spec_q;
  addr_q_t cmt_q;

  ras_spec_ctrl #(.ADDR(ADDR), .DEPTH(DEPTH), .INCR(INCR)) dut (
    .clk(clk), .reset(reset),
    .fetch_call_(fetch_call_), .fetch_pc(fetch_pc), .fetch_ret_(fetch_ret_),
    .ret_v(ret_v), .ret_addr(ret_addr),
    .commit_call_(commit_call_), .commit_pc(commit_pc), .commit_ret_(commit_ret_),
    .flush_(flush_), .spec_cnt(spec_cnt), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  function automatic addr_q_t stack_step(addr_q_t q, bit push, bit pop, logic [ADDR-1:0] v);
    addr_q_t r = q;
    if (push && pop && r.size() > 0) begin
      r[r.size()-1] = v;
    end else if (push) begin
      r.push_back(v);
      if (r.size() > DEPTH) void'(r.pop_front());
    end else if (pop && r.size() > 0) begin
      void'(r.pop_back());
    end
    return r;
  endfunction

  task automatic checkValue(input string tag, input logic [ADDR-1:0] got, input logic [ADDR-1:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic            exp_v;
    logic [ADDR-1:0] exp_addr;
    exp_v    = (spec_q.size() > 0);
    exp_addr = exp_v ? spec_q[spec_q.size()-1] : '0;
    checkValue({tag, ".ret_v"}, ADDR'(ret_v), ADDR'(exp_v));
    checkValue({tag, ".ret_addr"}, ret_addr, exp_addr);
    checkValue({tag, ".spec_cnt"}, ADDR'(spec_cnt), ADDR'(spec_q.size()));
    checkValue({tag, ".commit_cnt"}, ADDR'(commit_cnt), ADDR'(cmt_q.size()));
  endtask

  // Drives one cycle of strobes (active-high arguments), updates the model at the edge, then checks.
  task automatic applyStimulus(input string tag,
                               input bit call, input logic [ADDR-1:0] pc, input bit ret,
                               input bit ccall, input logic [ADDR-1:0] cpc, input bit cret,
                               input bit flush);
    fetch_call_  = ~call;
    fetch_pc     = pc;
    fetch_ret_   = ~ret;
    commit_call_ = ~ccall;
    commit_pc    = cpc;
    commit_ret_  = ~cret;
    flush_       = ~flush;
    @(posedge clk);
    cmt_q = stack_step(cmt_q, ccall, cret, cpc + ADDR'(INCR));
    if (flush) spec_q = cmt_q;
    else       spec_q = stack_step(spec_q, call, ret, pc + ADDR'(INCR));
    #1;
    fetch_call_  = 1'b1;
    fetch_ret_   = 1'b1;
    commit_call_ = 1'b1;
    commit_ret_  = 1'b1;
    flush_       = 1'b1;
    checkOutput(tag);
  endtask

  task automatic fcall(input string tag, input logic [ADDR-1:0] pc);
    applyStimulus(tag, 1'b1, pc, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic fret(input string tag);
    applyStimulus(tag, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [ADDR-1:0] rpc, rcpc;
    bit rc, rr, rcc, rcr, rf;

    #2;
    checkOutput("reset");
    #10;
    reset = 1'b0;
    #4;

    fcall("call100", 32'h100);
    fcall("call200", 32'h200);
    checkValue("plan.top204", ret_addr, 32'h204);
    fret("pop1");
    checkValue("plan.top104", ret_addr, 32'h104);
    fret("pop2");
    checkValue("plan.empty", ADDR'(spec_cnt), 32'h0);

    for (int i = 1; i <= 5; i++) fcall("ovf.call", ADDR'(i * 16));
    checkValue("plan.ovf_cnt", ADDR'(spec_cnt), 32'd4);
    checkValue("plan.ovf_top", ret_addr, 32'h54);
    for (int i = 0; i < 4; i++) fret("ovf.pop");
    checkValue("plan.ovf_drained", ADDR'(ret_v), 32'h0);

    fret("pop_empty");
    fcall("call80", 32'h80);
    checkValue("plan.top84", ret_addr, 32'h84);
    fcall("call_wrap", 32'hFFFF_FFFC);
    checkValue("plan.wrap", ret_addr, 32'h0);
    fret("wrap.pop1");
    fret("wrap.pop2");

    fcall("call100b", 32'h100);
    applyStimulus("replace", 1'b1, 32'h300, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    checkValue("plan.replace", ret_addr, 32'h304);
    fret("replace.pop");

    applyStimulus("ccall100", 1'b0, '0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
    fcall("fl.call100", 32'h100);
    fcall("fl.call500", 32'h500);
    applyStimulus("flush", 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    checkValue("plan.flush_top", ret_addr, 32'h104);
    applyStimulus("flush_commit", 1'b1, 32'h900, 1'b0, 1'b1, 32'h600, 1'b0, 1'b1);
    checkValue("plan.flush_commit_top", ret_addr, 32'h604);
    checkValue("plan.flush_commit_cnt", ADDR'(spec_cnt), 32'd2);

    for (int i = 0; i < 400; i++) begin
      rc  = ($urandom_range(0, 9) < 4);
      rr  = ($urandom_range(0, 9) < 4);
      rcc = ($urandom_range(0, 9) < 3);
      rcr = ($urandom_range(0, 9) < 3);
      rf  = ($urandom_range(0, 99) < 8);
      rpc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      rcpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      applyStimulus("rand", rc, rpc, rr, rcc, rcpc, rcr, rf);
    end

    fcall("pre_reset", 32'h700);
    applyStimulus("pre_reset.c", 1'b0, '0, 1'b0, 1'b1, 32'h800, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    spec_q.delete();
    cmt_q.delete();
    checkOutput("async_reset");
    #4;
    reset = 1'b0;
    #3;
    fcall("post_reset", 32'h40);
    checkValue("plan.post_reset", ret_addr, 32'h44);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
